// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter sequencer: command opcodes and FSM states.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_START        = 2'b00,
      OP_PAUSE_TOGGLE = 2'b01,
      OP_SET_RELOAD   = 2'b10,
      OP_SET_TERM     = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_PAUSE = 2'd3
   } state_e;

   localparam state_e STATE_RST = ST_IDLE;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for the counter sequencer: free-running up-counter that ticks when it
// matches the divide-minus-one value, clears on tick or clear_i, holds otherwise.
module counter_prescaler #(
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               run_i,
   input  logic [PRESC_W-1:0] presc_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] cnt_q, cnt_d;

   // An exact-match compare means a count already past a lowered presc_i
   // wraps through 2^PRESC_W before the next tick.
   assign tick_o = run_i && (cnt_q == presc_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Control FSM for the 8-bit counter datapath: command port, reload/terminal
// registers and strobe decode for cnt_en / cnt_load / done.
//
// state | meaning
// IDLE  | stopped, waiting for START
// LOAD  | one cycle, loads reload value into counter
// RUN   | counting on prescaler ticks
// PAUSE | counting suspended, prescaler held
module counter_sequencer
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [WIDTH-1:0]   cmd_data,
   input  logic               cfg_auto_reload,
   input  logic               cfg_dir_up,
   input  logic [PRESC_W-1:0] cfg_presc,
   input  logic [WIDTH-1:0]   cnt_value,
   output logic               cnt_en,
   output logic               cnt_load,
   output logic [WIDTH-1:0]   cnt_load_val,
   output logic               cnt_up,
   output logic               done,
   output logic               busy,
   output logic [1:0]         state_o
);

   state_e           state_q;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] term_q;
   logic             tick;
   logic             term_hit;
   logic             cmd_fire;
   cmd_op_e          op;
   logic             do_start, do_pause, do_reload, do_term;

   assign cmd_ready = (state_q != ST_LOAD);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign op        = cmd_op_e'(cmd_op);
   assign do_start  = cmd_fire && (op == OP_START);
   assign do_pause  = cmd_fire && (op == OP_PAUSE_TOGGLE);
   assign do_reload = cmd_fire && (op == OP_SET_RELOAD);
   assign do_term   = cmd_fire && (op == OP_SET_TERM);

   counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk     (clk),
      .rst     (rst),
      .clear_i ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
      .run_i   (state_q == ST_RUN),
      .presc_i (cfg_presc),
      .tick_o  (tick)
   );

   // Strobes decode the current state, so a command accepted this cycle
   // only shows its effect from the next cycle on.
   assign term_hit     = tick && (cnt_value == term_q);
   assign cnt_en       = tick && !term_hit;
   assign cnt_load     = (state_q == ST_LOAD) || (term_hit && cfg_auto_reload);
   assign done         = term_hit;
   assign cnt_load_val = reload_q;
   assign cnt_up       = cfg_dir_up;
   assign busy         = (state_q != ST_IDLE);
   assign state_o      = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= STATE_RST;
         reload_q <= '0;
         term_q   <= '1;
      end else begin
         if (do_reload) reload_q <= cmd_data;
         if (do_term)   term_q   <= cmd_data;
         case (state_q)
            ST_IDLE:  if (do_start) state_q <= ST_LOAD;
            ST_LOAD:  state_q <= ST_RUN;
            ST_RUN: begin
               if (do_start)                         state_q <= ST_LOAD;
               else if (do_pause)                    state_q <= ST_PAUSE;
               else if (term_hit && !cfg_auto_reload) state_q <= ST_IDLE;
            end
            ST_PAUSE: begin
               if (do_start)      state_q <= ST_LOAD;
               else if (do_pause) state_q <= ST_RUN;
            end
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 8-bit counter datapath.
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cfg_auto_reload;
   logic       cfg_dir_up;
   logic [3:0] cfg_presc;
   logic [7:0] cnt_value;
   logic       cnt_en;
   logic       cnt_load;
   logic [7:0] cnt_load_val;
   logic       cnt_up;
   logic       done;
   logic       busy;
   logic [1:0] state_o;

   int compared = 0;
   int mismatched = 0;

   localparam logic [1:0] START = 2'b00, PTOG = 2'b01, SRELOAD = 2'b10, STERM = 2'b11;

   always #5 clk = ~clk;

   counter_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cfg_auto_reload(cfg_auto_reload),
      .cfg_dir_up(cfg_dir_up), .cfg_presc(cfg_presc), .cnt_value(cnt_value),
      .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
      .cnt_up(cnt_up), .done(done), .busy(busy), .state_o(state_o)
   );

   // Datapath counter driven by the sequencer's strobes
   always @(posedge clk or posedge rst) begin
      if (rst)           cnt_value <= 8'd0;
      else if (cnt_load) cnt_value <= cnt_load_val;
      else if (cnt_en)   cnt_value <= cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1;
   end

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk8(tag, {7'd0, obs}, {7'd0, exp});
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      chk8(tag, {6'd0, obs}, {6'd0, exp});
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Presents a command for one cycle; returns at the next negedge
   task automatic send(input logic [1:0] op, input logic [7:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk1({tag, "_en"}, cnt_en, 1'b0);
      chk1({tag, "_load"}, cnt_load, 1'b0);
      chk1({tag, "_done"}, done, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'd0;
      cfg_auto_reload = 1'b0; cfg_dir_up = 1'b1; cfg_presc = 4'd0;
      cyc(); cyc();
      chk2("rst_state", state_o, 2'd0);
      chk1("rst_ready", cmd_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk_quiet("rst");
      chk8("rst_loadval", cnt_load_val, 8'd0);
      rst = 1'b0;
      cyc();

      // One-shot: reload 3, term 6, presc 0
      send(SRELOAD, 8'd3);
      send(STERM, 8'd6);
      chk1("os_idle_busy", busy, 1'b0);
      send(START, 8'd0);
      chk2("os_load_state", state_o, 2'd1);
      chk1("os_load_strobe", cnt_load, 1'b1);
      chk8("os_load_val", cnt_load_val, 8'd3);
      chk1("os_load_ready", cmd_ready, 1'b0);
      chk1("os_load_en", cnt_en, 1'b0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk1("os_run_en", cnt_en, 1'b1);
         chk1("os_run_done", done, 1'b0);
         chk8("os_run_cnt", cnt_value, 8'd3 + 8'(i));
         cyc();
      end
      chk1("os_done", done, 1'b1);
      chk1("os_done_en", cnt_en, 1'b0);
      chk1("os_done_load", cnt_load, 1'b0);
      cyc();
      chk1("os_after_busy", busy, 1'b0);
      chk2("os_after_state", state_o, 2'd0);
      chk_quiet("os_after");

      // Reset pulse in the middle of an auto-reload run
      cfg_auto_reload = 1'b1; cfg_presc = 4'd1;
      send(START, 8'd0);
      cyc(); cyc(); cyc();
      chk2("mid_state_run", state_o, 2'd2);
      rst = 1'b1;
      #1;
      chk2("mid_rst_state", state_o, 2'd0);
      chk1("mid_rst_ready", cmd_ready, 1'b1);
      chk1("mid_rst_busy", busy, 1'b0);
      chk_quiet("mid_rst");
      chk8("mid_rst_loadval", cnt_load_val, 8'd0);
      cyc();
      rst = 1'b0;
      cyc();

      // Terminal register back at 0xFF: count FD, FE then done at FF
      cfg_auto_reload = 1'b0; cfg_presc = 4'd0;
      send(SRELOAD, 8'hFD);
      send(START, 8'd0);
      chk8("ff_load_val", cnt_load_val, 8'hFD);
      cyc();
      chk1("ff_en0", cnt_en, 1'b1);
      cyc();
      chk1("ff_en1", cnt_en, 1'b1);
      cyc();
      chk8("ff_cnt", cnt_value, 8'hFF);
      chk1("ff_done", done, 1'b1);
      cyc();
      chk1("ff_idle_busy", busy, 1'b0);

      // Auto-reload: reload 0, term 2, presc 2
      cfg_auto_reload = 1'b1; cfg_presc = 4'd2;
      send(SRELOAD, 8'd0);
      send(STERM, 8'd2);
      send(START, 8'd0);
      chk1("ar_load", cnt_load, 1'b1);
      cyc();
      for (int r = 0; r < 18; r++) begin
         chk1("ar_en", cnt_en, ((r % 3) == 2) && ((r % 9) != 8));
         chk1("ar_done", done, (r % 9) == 8);
         chk1("ar_reload", cnt_load, (r % 9) == 8);
         chk1("ar_busy", busy, 1'b1);
         cyc();
      end

      // Pause with the prescaler at 0; it advances to 1 on the accepting edge
      chk8("pz_cnt", cnt_value, 8'd0);
      send(PTOG, 8'd0);
      for (int i = 0; i < 20; i++) begin
         chk2("pz_state", state_o, 2'd3);
         chk_quiet("pz");
         cyc();
      end
      send(PTOG, 8'd0);
      chk2("pz_resume_state", state_o, 2'd2);
      chk1("pz_resume_en0", cnt_en, 1'b0);
      cyc();
      chk1("pz_resume_en1", cnt_en, 1'b1);
      cyc();

      // START on an auto-reload terminal cycle: cnt=1, presc=0, term at offset 5
      for (int i = 0; i < 5; i++) cyc();
      chk8("rs_term_cnt", cnt_value, 8'd2);
      chk1("rs_term_done", done, 1'b1);
      chk1("rs_term_load", cnt_load, 1'b1);
      chk1("rs_term_ready", cmd_ready, 1'b1);
      send(START, 8'd0);
      chk2("rs_load_state", state_o, 2'd1);
      chk1("rs_load_strobe", cnt_load, 1'b1);
      chk1("rs_load_ready", cmd_ready, 1'b0);
      chk1("rs_load_done", done, 1'b0);
      cyc();
      chk2("rs_run_state", state_o, 2'd2);
      chk1("rs_run_ready", cmd_ready, 1'b1);

      // Count down: reload 5, term 1, presc 0, one-shot
      cfg_auto_reload = 1'b0; cfg_dir_up = 1'b0; cfg_presc = 4'd0;
      send(SRELOAD, 8'd5);
      send(STERM, 8'd1);
      send(START, 8'd0);
      chk1("dn_up", cnt_up, 1'b0);
      chk8("dn_load_val", cnt_load_val, 8'd5);
      chk1("dn_load", cnt_load, 1'b1);
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk8("dn_cnt", cnt_value, 8'd5 - 8'(i));
         chk1("dn_en", cnt_en, 1'b1);
         cyc();
      end
      chk8("dn_term_cnt", cnt_value, 8'd1);
      chk1("dn_done", done, 1'b1);
      chk1("dn_done_en", cnt_en, 1'b0);
      cyc();
      chk2("dn_idle", state_o, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
